// File: rtl/door_plate_ctl.sv
// Pressure-plate door controller: every output updates on the clk after a v_tick rising edge and holds otherwise.
// No backpressure; button_pressed is asserted only while the door is fully open.
module door_plate_ctl #(
  parameter int PLATE_XMIN  = 150,
  parameter int PLATE_XMAX  = 200,
  parameter int DOOR_XMIN   = 350,
  parameter int DOOR_XMAX   = 450,
  parameter int DOOR_HEIGHT = 120,
  parameter int STEP        = 4,
  parameter int HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_tick,
  input  logic [11:0] xpos_player1,
  input  logic [11:0] xpos_player2,
  output logic        button_pressed,
  output logic [11:0] door_open_amt,
  output logic [1:0]  door_state,
  output logic        plate_active
);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } state_e;

  localparam logic [11:0] PL_MIN = 12'(PLATE_XMIN);
  localparam logic [11:0] PL_MAX = 12'(PLATE_XMAX);
  localparam logic [11:0] DR_MIN = 12'(DOOR_XMIN);
  localparam logic [11:0] DR_MAX = 12'(DOOR_XMAX);
  localparam logic [11:0] HEIGHT = 12'(DOOR_HEIGHT);
  localparam logic [11:0] STP    = 12'(STEP);
  localparam logic [11:0] HOLD   = 12'(HOLD_FRAMES);

  state_e      state_q;
  logic [11:0] amt_q;
  logic [11:0] hold_q;
  logic        btn_q;
  logic        plate_q;
  logic        v_tick_old_q;

  logic        frame;
  logic        on_plate;
  logic        occupied;
  logic [11:0] amt_up_d;
  logic [11:0] amt_dn_d;

  assign frame    = v_tick && !v_tick_old_q;
  assign on_plate = (xpos_player1 >= PL_MIN && xpos_player1 <= PL_MAX) ||
                    (xpos_player2 >= PL_MIN && xpos_player2 <= PL_MAX);
  // Strict bounds: a player pushed against the closed barrier edge does not hold the door.
  assign occupied = (xpos_player1 > DR_MIN && xpos_player1 < DR_MAX) ||
                    (xpos_player2 > DR_MIN && xpos_player2 < DR_MAX);

  // Saturate before stepping so the 12-bit amount never wraps.
  assign amt_up_d = (HEIGHT - amt_q <= STP) ? HEIGHT : amt_q + STP;
  assign amt_dn_d = (amt_q <= STP) ? 12'd0 : amt_q - STP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLOSED;
      amt_q        <= 12'd0;
      hold_q       <= 12'd0;
      btn_q        <= 1'b0;
      plate_q      <= 1'b0;
      v_tick_old_q <= 1'b0;
    end else begin
      v_tick_old_q <= v_tick;
      if (frame) begin
        plate_q <= on_plate;
        unique case (state_q)
          CLOSED: begin
            if (on_plate) begin
              state_q <= OPENING;
              amt_q   <= amt_up_d;
            end
          end
          OPENING: begin
            if (on_plate || occupied) begin
              amt_q <= amt_up_d;
              if (amt_up_d == HEIGHT) begin
                state_q <= OPEN;
                hold_q  <= HOLD;
                btn_q   <= 1'b1;
              end
            end else begin
              amt_q   <= amt_dn_d;
              state_q <= (amt_dn_d == 12'd0) ? CLOSED : CLOSING;
            end
          end
          OPEN: begin
            if (on_plate || occupied) begin
              hold_q <= HOLD;
            end else if (hold_q != 12'd0) begin
              hold_q <= hold_q - 12'd1;
            end else begin
              state_q <= CLOSING;
              amt_q   <= amt_dn_d;
              btn_q   <= 1'b0;
            end
          end
          CLOSING: begin
            if (on_plate) begin
              state_q <= OPENING;
              amt_q   <= amt_up_d;
            end else begin
              amt_q <= amt_dn_d;
              if (amt_dn_d == 12'd0) state_q <= CLOSED;
            end
          end
        endcase
      end
    end
  end

  assign button_pressed = btn_q;
  assign door_open_amt  = amt_q;
  assign door_state     = state_q;
  assign plate_active   = plate_q;

endmodule

// File: doc/door_plate_ctl.md
Name: door_plate_ctl

Overview:
- Pressure-plate and door controller for the two-player level; produces the `button_pressed` qualifier consumed by the player-movement controller.
- Watches both player x positions. When either player stands on the plate, the door barrier (x range DOOR_XMIN..DOOR_XMAX) is animated open, one step per frame.
- `button_pressed` asserts only while the door is fully open.
- Exports the door opening amount and state to the door sprite renderer.

Parameters:
- PLATE_XMIN, 150, left edge of plate (inclusive)
- PLATE_XMAX, 200, right edge of plate (inclusive)
- DOOR_XMIN, 350, left edge of door zone
- DOOR_XMAX, 450, right edge of door zone
- DOOR_HEIGHT, 120, opening amount when fully open (pixels)
- STEP, 4, opening change per frame
- HOLD_FRAMES, 60, frames the door stays open after the plate and door zone are vacated

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- v_tick  in  1  frame marker; each rising edge is one frame event
- xpos_player1  in  12  player 1 x position
- xpos_player2  in  12  player 2 x position
- button_pressed  out  1  door fully open; movement controller may let players cross the door zone
- door_open_amt  out  12  current opening, 0..DOOR_HEIGHT
- door_state  out  2  0=CLOSED, 1=OPENING, 2=OPEN, 3=CLOSING
- plate_active  out  1  registered: some player is on the plate

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=CLOSED, door_open_amt=0, button_pressed=0, plate_active=0.
  - Hold counter=0, v_tick_old=0.
  - Reset mid-animation aborts immediately to these values.
- Frame event:
  - frame = v_tick && !v_tick_old; v_tick_old registers every clk when not in reset.
  - All state, amount, counter, plate_active and button_pressed updates happen only on frame cycles; outputs hold otherwise.
- Combinational conditions, from current inputs:
  - on_plate = any player with PLATE_XMIN <= x <= PLATE_XMAX.
  - occupied = any player with DOOR_XMIN < x < DOOR_XMAX (strict, so a player blocked at the door edge does not count).
- plate_active <= on_plate on every frame.
- CLOSED:
  - If on_plate: state->OPENING and amt <= min(STEP, DOOR_HEIGHT).
  - Otherwise stay.
- OPENING:
  - If on_plate or occupied: amt <= min(amt+STEP, DOOR_HEIGHT). If the result equals DOOR_HEIGHT: state->OPEN, hold <= HOLD_FRAMES.
  - Else: state->CLOSING and amt <= amt-STEP, saturating at 0. If the result is 0: state->CLOSED.
- OPEN:
  - amt stays DOOR_HEIGHT.
  - If on_plate or occupied: hold <= HOLD_FRAMES.
  - Else if hold != 0: hold <= hold-1.
  - Else (hold==0, free): state->CLOSING and amt <= DOOR_HEIGHT-STEP.
- CLOSING:
  - If on_plate: state->OPENING and amt <= min(amt+STEP, DOOR_HEIGHT). Occupied alone cannot occur while closing, since button_pressed is 0.
  - Else: amt <= max(amt-STEP, 0). When 0: state->CLOSED.
- button_pressed is registered:
  - Set to 1 on the same frame edge that state becomes OPEN.
  - Cleared on the same frame edge that state leaves OPEN.
  - Never 1 unless amt==DOOR_HEIGHT.
- Arithmetic:
  - 12-bit unsigned. Saturation comparisons are done before add/subtract, so no wrap at 0 or DOOR_HEIGHT.
  - DOOR_HEIGHT not a multiple of STEP is legal; the last step clips.
- Simultaneous events:
  - on_plate has priority over closing.
  - occupied has priority over the hold countdown expiring.
  - Both players on the plate is treated as one.
- door_state is the encoded current state and is registered.

Test Plan:
- Reset, players at x=0, 10 frames -> state CLOSED, amt=0, button_pressed=0 throughout.
- Player1 x=170 held -> amt 4,8,...,120 over 30 frames. button_pressed=1 and state=OPEN on the 30th frame edge, not before.
- Open, player1 moves to x=0, player2 x=0 -> 60 frames of OPEN, then CLOSING. amt=116 on the next frame, 0 after 30 closing frames, then CLOSED.
- Open, player2 at x=400 with plate empty -> hold reloads every frame and the door never closes. Move player2 to x=500 -> closes after 60 frames.
- CLOSING at amt=60, player1 steps onto x=150 -> OPENING, amt=64 on the next frame. x=201 during OPENING (plate left) -> CLOSING from that frame.
- v_tick held high for 100 clk -> exactly one update. Assert rst while amt=80 OPENING -> next cycle amt=0, CLOSED, button_pressed=0.
